// File: rtl/addertree_final_acc_pkg.sv
// Shared widths and FSM encodings for the adder-tree final accumulator.
package addertree_final_acc_pkg;

    localparam int ROW_LSB = 5;
    localparam int ROW_W   = 15;
    localparam int LO_W    = 5;
    localparam int PSUM_W  = 20;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

endpackage

// File: rtl/addertree_cpa.sv
// Carry-propagate adder that resolves the sum and carry rows of the reduction tree.
// The carry out of the top column is intentionally dropped.
module addertree_cpa
    import addertree_final_acc_pkg::*;
(
    input  logic [ROW_W-1:0] row_s,
    input  logic [ROW_W-1:0] row_c,
    output logic [ROW_W-1:0] row_sum
);

    assign row_sum = row_s + row_c;

endmodule

// File: rtl/addertree_final_acc.sv
// Resolves carry-save rows into a signed partial sum and accumulates across a burst.
// Optional output saturation is enabled with the ADDERTREE_ACC_SAT_EN macro.
module addertree_final_acc
    import addertree_final_acc_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [ROW_W-1:0] in_row_s,
    input  logic [ROW_W-1:0] in_row_c,
    input  logic [LO_W-1:0]  in_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    logic                     vld_p1_q, vld_p1_d;
    logic                     last_p1_q, last_p1_d;
    logic [ROW_W-1:0]         s_p1_q, s_p1_d;
    logic [ROW_W-1:0]         c_p1_q, c_p1_d;
    logic [LO_W-1:0]          lo_p1_q, lo_p1_d;

    logic [0:0]               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     out_ovf_q, out_ovf_d;

    logic                     stall;
    logic                     accept;
    logic                     advance;
    logic [ROW_W-1:0]         row_sum_p2;
    logic signed [PSUM_W-1:0] psum_p2;
    logic signed [ACC_W-1:0]  psum_ext_p2;
    logic signed [ACC_W-1:0]  acc_base_p2;
    logic signed [ACC_W-1:0]  acc_next_p2;

`ifdef ADDERTREE_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Returns {overflow_flag, clamped_value}.
    function automatic logic [OUT_W:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] lim;
        if (v > OUT_MAX) begin
            lim     = OUT_MAX;
            sat_out = {1'b1, lim[OUT_W-1:0]};
        end else if (v < OUT_MIN) begin
            lim     = OUT_MIN;
            sat_out = {1'b1, lim[OUT_W-1:0]};
        end else begin
            sat_out = {1'b0, v[OUT_W-1:0]};
        end
    endfunction
`endif

    // Only a last term facing a held, unaccepted result blocks the pipe.
    assign stall    = vld_p1_q && last_p1_q && out_valid_q && !out_ready;
    assign in_ready = !vld_p1_q || !stall;
    assign accept   = in_valid && in_ready;
    assign advance  = vld_p1_q && !stall;

    // ---- stage p0 -> p1: input capture ----
    always_comb begin
        vld_p1_d  = vld_p1_q;
        last_p1_d = last_p1_q;
        s_p1_d    = s_p1_q;
        c_p1_d    = c_p1_q;
        lo_p1_d   = lo_p1_q;
        if (!stall) begin
            vld_p1_d = accept;
        end
        if (accept) begin
            last_p1_d = in_last;
            s_p1_d    = in_row_s;
            c_p1_d    = in_row_c;
            lo_p1_d   = in_lo;
        end
    end

    // ---- stage p1 -> p2: row resolve and accumulate ----
    addertree_cpa u_cpa (
        .row_s   (s_p1_q),
        .row_c   (c_p1_q),
        .row_sum (row_sum_p2)
    );

    assign psum_p2     = {row_sum_p2, lo_p1_q[ROW_LSB-1:0]};
    assign psum_ext_p2 = ACC_W'(psum_p2);
    assign acc_base_p2 = (state_q == ST_IDLE) ? '0 : acc_q;
    assign acc_next_p2 = acc_base_p2 + psum_ext_p2;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (advance) begin
            if (last_p1_q) begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                out_valid_d = 1'b1;
`ifdef ADDERTREE_ACC_SAT_EN
                {out_ovf_d, out_data_d} = sat_out(acc_next_p2);
`else
                out_ovf_d   = 1'b0;
                out_data_d  = acc_next_p2[OUT_W-1:0];
`endif
            end else begin
                state_d = ST_ACCUM;
                acc_d   = acc_next_p2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Payload is qualified by vld_p1_q, so it carries no reset.
    always_ff @(posedge clk) begin
        last_p1_q <= last_p1_d;
        s_p1_q    <= s_p1_d;
        c_p1_q    <= c_p1_d;
        lo_p1_q   <= lo_p1_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_addertree_final_acc.sv
// Directed self-checking bench for addertree_final_acc.
module tb_addertree_final_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [14:0] in_row_s;
    logic [14:0] in_row_c;
    logic [4:0]  in_lo;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    addertree_final_acc #(.ACC_W(32), .OUT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_row_s  (in_row_s),
        .in_row_c  (in_row_c),
        .in_lo     (in_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // Presents one beat for exactly one rising edge; called at a falling edge.
    task automatic beat(input logic [14:0] s, input logic [14:0] c,
                        input logic [4:0] lo, input logic last);
        in_valid = 1'b1;
        in_row_s = s;
        in_row_c = c;
        in_lo    = lo;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%0h want=0", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", out_ovf); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        beat(15'h0001, 15'h0002, 5'd5, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b want=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 16'd101) begin bad++; $display("FAIL single_data got=%0d want=101", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%0b want=0", out_ovf); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_clear got=%0b want=0", out_valid); end
    endtask

    task automatic test_negative();
        beat(15'h7FFF, 15'h0000, 5'd0, 1'b1);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL neg_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 16'hFFE0) begin bad++; $display("FAIL neg_data got=%0h want=ffe0", out_data); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          nres;
        logic [15:0] seen;
        nres = 0;
        seen = 16'h0000;
        out_ready = 1'b1;
        beat(15'h0000, 15'h0000, 5'd10, 1'b0);
        beat(15'h0000, 15'h0000, 5'd20, 1'b0);
        beat(15'h7FFF, 15'h0000, 5'd27, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) begin
                nres++;
                seen = out_data;
            end
        end
        total++; if (nres !== 1) begin bad++; $display("FAIL b2b_count got=%0d want=1", nres); end
        total++; if (seen !== 16'd25) begin bad++; $display("FAIL b2b_data got=%0d want=25", seen); end
        beat(15'h0000, 15'h0000, 5'd7, 1'b1);
        @(negedge clk);
        total++; if (out_data !== 16'd7) begin bad++; $display("FAIL b2b_restart got=%0d want=7", out_data); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(15'h0000, 15'h0000, 5'd1, 1'b1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_first got=%0b want=1", in_ready); end
        beat(15'h0000, 15'h0000, 5'd2, 1'b1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall got=%0b want=0", in_ready); end
        total++; if (out_data !== 16'd1) begin bad++; $display("FAIL bp_held got=%0d want=1", out_data); end
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall2 got=%0b want=0", in_ready); end
        total++; if (out_data !== 16'd1) begin bad++; $display("FAIL bp_held2 got=%0d want=1", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 16'd2) begin bad++; $display("FAIL bp_next_data got=%0d want=2", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_nonlast_held();
        out_ready = 1'b0;
        beat(15'h0000, 15'h0000, 5'd3, 1'b1);
        beat(15'h0000, 15'h0000, 5'd4, 1'b0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL held_nonlast_ready got=%0b want=1", in_ready); end
        beat(15'h0000, 15'h0000, 5'd5, 1'b1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL held_last_stall got=%0b want=0", in_ready); end
        total++; if (out_data !== 16'd3) begin bad++; $display("FAIL held_old got=%0d want=3", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL held_new_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 16'd9) begin bad++; $display("FAIL held_new_data got=%0d want=9", out_data); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL held_clear got=%0b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        beat(15'h0000, 15'h0000, 5'd6, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstheld_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rstheld_data got=%0h want=0", out_data); end
        out_ready = 1'b1;
        beat(15'h0000, 15'h0000, 5'd10, 1'b0);
        beat(15'h0000, 15'h0000, 5'd11, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%0b want=1", in_ready); end
        beat(15'h0000, 15'h0000, 5'd4, 1'b1);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_after_valid got=%0b want=1", out_valid); end
        total++; if (out_data !== 16'd4) begin bad++; $display("FAIL rstmid_after_data got=%0d want=4", out_data); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        logic [15:0] exp_data;
        logic        exp_ovf;
`ifdef ADDERTREE_ACC_SAT_EN
        exp_data = 16'h7FFF;
        exp_ovf  = 1'b1;
`else
        exp_data = 16'hFFFF;
        exp_ovf  = 1'b0;
`endif
        out_ready = 1'b1;
        beat(15'h3FFF, 15'h0000, 5'd31, 1'b1);
        @(negedge clk);
        total++; if (out_data !== exp_data) begin bad++; $display("FAIL sat_data got=%0h want=%0h", out_data, exp_data); end
        total++; if (out_ovf !== exp_ovf) begin bad++; $display("FAIL sat_ovf got=%0b want=%0b", out_ovf, exp_ovf); end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_row_s  = '0;
        in_row_c  = '0;
        in_lo     = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_negative();
        test_back_to_back();
        test_backpressure();
        test_nonlast_held();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
